// File: rtl/comparator_scheduler.sv
// Time-multiplexes N_CH meas/thr pairs onto one shared comparator; one pair per ISSUE/WAIT, vectors update atomically on DONE.
// Latency 2*N_CH+1 cycles from sta with a 1-cycle comparator; sta outside IDLE is dropped, a missing cmp_done is bounded by TIMEOUT.
module comparator_scheduler #(
  parameter int N_CH    = 4,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sta,
  input  logic [N_CH*WIDTH-1:0] meas_bus,
  input  logic [N_CH*WIDTH-1:0] thr_bus,
  output logic                  cmp_sta,
  output logic [WIDTH-1:0]      cmp_a,
  output logic [WIDTH-1:0]      cmp_b,
  input  logic                  cmp_agb,
  input  logic                  cmp_alb,
  input  logic                  cmp_done,
  output logic [N_CH-1:0]       gt_vec,
  output logic [N_CH-1:0]       lt_vec,
  output logic [N_CH-1:0]       eq_vec,
  output logic                  busy,
  output logic                  done_sig,
  output logic                  err_timeout
);

  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_CH - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d, idx_inc;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_CH-1:0]  sh_gt_q, sh_gt_d, sh_lt_q, sh_lt_d, sh_eq_q, sh_eq_d;
  logic [N_CH-1:0]  gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;
  logic [WIDTH-1:0] cmp_a_q, cmp_a_d, cmp_b_q, cmp_b_d;
  logic             cmp_sta_q, cmp_sta_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic             snap_ld, adv;
  logic [WIDTH-1:0] snap_meas_q [N_CH];
  logic [WIDTH-1:0] snap_thr_q  [N_CH];

  assign idx_inc = idx_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    sh_gt_d   = sh_gt_q;
    sh_lt_d   = sh_lt_q;
    sh_eq_d   = sh_eq_q;
    gt_d      = gt_q;
    lt_d      = lt_q;
    eq_d      = eq_q;
    cmp_sta_d = 1'b0;
    cmp_a_d   = cmp_a_q;
    cmp_b_d   = cmp_b_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    snap_ld   = 1'b0;
    adv       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sta) begin
          // Channel 0 operands come straight off the bus since the snapshot loads on this same edge.
          snap_ld   = 1'b1;
          idx_d     = '0;
          err_d     = 1'b0;
          busy_d    = 1'b1;
          cmp_sta_d = 1'b1;
          cmp_a_d   = meas_bus[WIDTH-1:0];
          cmp_b_d   = thr_bus[WIDTH-1:0];
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cmp_done) begin
          sh_gt_d[idx_q] = cmp_agb;
          sh_lt_d[idx_q] = cmp_alb;
          sh_eq_d[idx_q] = ~cmp_agb & ~cmp_alb;
          adv = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          sh_gt_d[idx_q] = 1'b0;
          sh_lt_d[idx_q] = 1'b0;
          sh_eq_d[idx_q] = 1'b0;
          err_d = 1'b1;
          adv   = 1'b1;
        end
        if (adv) begin
          if (idx_q == LAST_IDX) begin
            // Load from next-state shadows so the last channel lands in the same atomic update.
            gt_d    = sh_gt_d;
            lt_d    = sh_lt_d;
            eq_d    = sh_eq_d;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            idx_d     = idx_inc;
            cmp_sta_d = 1'b1;
            cmp_a_d   = snap_meas_q[idx_inc];
            cmp_b_d   = snap_thr_q[idx_inc];
            state_d   = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      sh_gt_q   <= '0;
      sh_lt_q   <= '0;
      sh_eq_q   <= '0;
      gt_q      <= '0;
      lt_q      <= '0;
      eq_q      <= '0;
      cmp_sta_q <= 1'b0;
      cmp_a_q   <= '0;
      cmp_b_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      sh_gt_q   <= sh_gt_d;
      sh_lt_q   <= sh_lt_d;
      sh_eq_q   <= sh_eq_d;
      gt_q      <= gt_d;
      lt_q      <= lt_d;
      eq_q      <= eq_d;
      cmp_sta_q <= cmp_sta_d;
      cmp_a_q   <= cmp_a_d;
      cmp_b_q   <= cmp_b_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_CH; i++) begin
        snap_meas_q[i] <= '0;
        snap_thr_q[i]  <= '0;
      end
    end else if (snap_ld) begin
      for (int i = 0; i < N_CH; i++) begin
        snap_meas_q[i] <= meas_bus[i*WIDTH +: WIDTH];
        snap_thr_q[i]  <= thr_bus[i*WIDTH +: WIDTH];
      end
    end
  end

  assign cmp_sta     = cmp_sta_q;
  assign cmp_a       = cmp_a_q;
  assign cmp_b       = cmp_b_q;
  assign gt_vec      = gt_q;
  assign lt_vec      = lt_q;
  assign eq_vec      = eq_q;
  assign busy        = busy_q;
  assign done_sig    = done_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_comparator_scheduler.sv
// Directed bench for comparator_scheduler with a behavioural comparator and a result scoreboard.
module tb_comparator_scheduler;
  localparam int NC = 4;
  localparam int W  = 32;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst, sta;
  logic [NC*W-1:0] meas_bus, thr_bus;
  logic          cmp_sta, cmp_agb, cmp_alb, cmp_done;
  logic [W-1:0]  cmp_a, cmp_b;
  logic [NC-1:0] gt_vec, lt_vec, eq_vec;
  logic          busy, done_sig, err_timeout;

  comparator_scheduler #(.N_CH(NC), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .sta(sta), .meas_bus(meas_bus), .thr_bus(thr_bus),
    .cmp_sta(cmp_sta), .cmp_a(cmp_a), .cmp_b(cmp_b),
    .cmp_agb(cmp_agb), .cmp_alb(cmp_alb), .cmp_done(cmp_done),
    .gt_vec(gt_vec), .lt_vec(lt_vec), .eq_vec(eq_vec),
    .busy(busy), .done_sig(done_sig), .err_timeout(err_timeout)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [NC-1:0] gt;
    logic [NC-1:0] lt;
    logic [NC-1:0] eq;
    logic          err;
    int            dcyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   lat = 1;
  int   drop_ch = -1;
  int   ill_ch = -1;
  int   step_id = 0;
  logic [W-1:0] snap_m [NC];
  logic [W-1:0] snap_t [NC];

  // Total-order key for non-NaN IEEE singles (zeros are avoided by the stimulus).
  function automatic logic [1:0] fcmp(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] ka, kb;
    ka = a[W-1] ? ~a : (a | 32'h8000_0000);
    kb = b[W-1] ? ~b : (b | 32'h8000_0000);
    return {ka > kb, ka < kb};
  endfunction

  function automatic logic [W-1:0] rnd_f();
    logic [W-1:0] r;
    r = $urandom;
    r[30:23] = 8'($urandom_range(1, 254));
    return r;
  endfunction

  // Behavioural comparator: done and flags appear lat cycles after cmp_sta.
  int rem = 0, mdl_ch = 0, cur_ch = 0, seen_step = 0;
  logic [W-1:0] pa, pb;
  always @(negedge clk) begin
    if (!rst) begin
      rem = 0; cmp_done = 1'b0; cmp_agb = 1'b0; cmp_alb = 1'b0;
    end else begin
      cmp_done = 1'b0;
      if (rem > 0) begin
        rem = rem - 1;
        if (rem == 0 && cur_ch != drop_ch) begin
          cmp_done = 1'b1;
          if (cur_ch == ill_ch) {cmp_agb, cmp_alb} = 2'b11;
          else {cmp_agb, cmp_alb} = fcmp(pa, pb);
        end
      end
      if (cmp_sta) begin
        if (step_id != seen_step) begin seen_step = step_id; mdl_ch = 0; end
        rem = lat; pa = cmp_a; pb = cmp_b; cur_ch = mdl_ch; mdl_ch = mdl_ch + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (done_sig === 1'b1) begin
      if (sb.size() == 0) chk("spurious_done", 32'(done_sig), 32'd0);
      else begin
        e = sb.pop_front();
        chk("sb_gt", 32'(gt_vec), 32'(e.gt));
        chk("sb_lt", 32'(lt_vec), 32'(e.lt));
        chk("sb_eq", 32'(eq_vec), 32'(e.eq));
        chk("sb_err", 32'(err_timeout), 32'(e.err));
        chk("sb_done_cycle", 32'(cyc), 32'(e.dcyc));
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    monitor();
  endtask

  task automatic push_exp();
    exp_t e;
    logic [1:0] r;
    int tot;
    e.gt = '0; e.lt = '0; e.eq = '0; e.err = 1'b0;
    tot = 0;
    for (int i = 0; i < NC; i++) begin
      if (i == drop_ch) begin
        tot += 1 + TO; e.err = 1'b1;
      end else begin
        tot += 1 + lat;
        if (i == ill_ch) r = 2'b11;
        else r = fcmp(meas_bus[i*W +: W], thr_bus[i*W +: W]);
        e.gt[i] = r[1]; e.lt[i] = r[0]; e.eq[i] = ~r[1] & ~r[0];
      end
    end
    e.dcyc = cyc + tot + 1;
    sb.push_back(e);
  endtask

  task automatic start();
    sta = 1'b1;
    step_id++;
    push_exp();
    tick();
    sta = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 400) begin tick(); n++; end
    chk("drain_bound", 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_cmp_sta"}, 32'(cmp_sta), 32'd0);
    chk({p, "_cmp_a"}, cmp_a, 32'd0);
    chk({p, "_cmp_b"}, cmp_b, 32'd0);
    chk({p, "_gt"}, 32'(gt_vec), 32'd0);
    chk({p, "_lt"}, 32'(lt_vec), 32'd0);
    chk({p, "_eq"}, 32'(eq_vec), 32'd0);
    chk({p, "_busy"}, 32'(busy), 32'd0);
    chk({p, "_done"}, 32'(done_sig), 32'd0);
    chk({p, "_err"}, 32'(err_timeout), 32'd0);
  endtask

  task automatic set_basic();
    meas_bus = {32'hBF00_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000};
    thr_bus  = {32'hBF80_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000};
  endtask

  initial begin
    rst = 1'b0; sta = 1'b0; meas_bus = '0; thr_bus = '0;
    repeat (3) tick();
    chk_zero("reset");
    rst = 1'b1;
    repeat (2) tick();

    // Basic step: cycle-exact strobes, busy window and fixed vectors.
    set_basic();
    start();
    for (int c = 1; c <= 10; c++) begin
      chk("basic_cmp_sta", 32'(cmp_sta), 32'((c % 2 == 1) && (c <= 7)));
      chk("basic_busy", 32'(busy), 32'(c <= 9));
      if (c < 10) tick();
    end
    chk("basic_gt", 32'(gt_vec), 32'b1100);
    chk("basic_lt", 32'(lt_vec), 32'b0001);
    chk("basic_eq", 32'(eq_vec), 32'b0010);
    drain(); tick();

    // Reset in WAIT of channel 2 aborts the step with no done pulse.
    start();
    repeat (5) tick();
    #1 rst = 1'b0;
    #1 chk_zero("abort");
    sb.delete();
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      chk("abort_no_done", 32'(done_sig), 32'd0);
    end

    // Snapshot: buses churn every cycle after sta; operands must stay at sampled values.
    for (int i = 0; i < NC; i++) begin
      meas_bus[i*W +: W] = rnd_f();
      thr_bus[i*W +: W]  = rnd_f();
    end
    thr_bus[W +: W] = meas_bus[W +: W];
    for (int i = 0; i < NC; i++) begin
      snap_m[i] = meas_bus[i*W +: W];
      snap_t[i] = thr_bus[i*W +: W];
    end
    start();
    for (int c = 1; c <= 8; c++) begin
      chk("snap_cmp_a", cmp_a, snap_m[(c-1)/2]);
      chk("snap_cmp_b", cmp_b, snap_t[(c-1)/2]);
      for (int i = 0; i < NC; i++) begin
        meas_bus[i*W +: W] = rnd_f();
        thr_bus[i*W +: W]  = rnd_f();
      end
      tick();
    end
    drain(); tick();

    // sta at relative cycles 4 and 9 is ignored; cycle 10 starts a fresh step.
    set_basic();
    start();
    repeat (3) tick();
    sta = 1'b1; tick(); sta = 1'b0;
    repeat (4) tick();
    sta = 1'b1; tick();
    start();
    drain(); tick();

    // Comparator drops ch1: zeros for ch1, sticky error, cleared by next sta.
    set_basic();
    drop_ch = 1;
    start();
    drain();
    chk("to_err_set", 32'(err_timeout), 32'd1);
    chk("to_gt", 32'(gt_vec), 32'b1100);
    chk("to_lt", 32'(lt_vec), 32'b0001);
    chk("to_eq", 32'(eq_vec), 32'b0000);
    tick();
    drop_ch = -1;
    start();
    chk("to_err_cleared", 32'(err_timeout), 32'd0);
    drain(); tick();

    // Latency 3, two back-to-back steps at the earliest restart cycle.
    lat = 3;
    set_basic();
    start();
    drain(); tick();
    start();
    drain();
    chk("lat_gt", 32'(gt_vec), 32'b1100);
    chk("lat_eq", 32'(eq_vec), 32'b0010);
    tick();

    // Illegal agb=alb=1 on ch2 is captured as-is with eq cleared.
    lat = 1;
    ill_ch = 2;
    start();
    drain();
    chk("ill_gt", 32'(gt_vec), 32'b1100);
    chk("ill_lt", 32'(lt_vec), 32'b0101);
    chk("ill_eq", 32'(eq_vec), 32'b0010);
    ill_ch = -1;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
